// File: rtl/bus_bridge_target_uart_link.sv
// Target-side UART link: one bridge request -> 4-byte UART frame, 2-byte UART reply -> bridge response.
// Latency: first wr_en 1 cycle after acceptance; resp_valid 1 cycle after the flags byte is seen.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until resp_ready. Timeout: BUS_BRIDGE_UART_TIMEOUT_EN.

package bus_bridge_pkg;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic [7:0] read_data;
        logic       is_write;
    } bus_bridge_resp_t;
endpackage

// Byte UART, 8N1. Deliberately has no reset: a byte in flight survives a link reset.
// Registers are encoded so the all-zero power-up state is idle with the line high.
module uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50m,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    input  logic       clear,
    output logic       Tx,
    output logic       Tx_busy,
    input  logic       Rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [7:0] data_out
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;

    logic [9:0]  tx_shift_q;
    logic [15:0] tx_cnt_q;
    logic [3:0]  tx_bit_q;
    logic        tx_busy_q;

    logic        rx_meta_n_q, rx_sync_n_q;
    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  data_out_q;
    logic        ready_q;

    assign Tx       = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign Tx_busy  = tx_busy_q;
    assign ready    = ready_q;
    assign data_out = data_out_q;

    always_ff @(posedge clk_50m) begin
        if (!tx_busy_q) begin
            if (wr_en) begin
                tx_shift_q <= {1'b1, data_in, 1'b0};
                tx_busy_q  <= 1'b1;
                tx_cnt_q   <= '0;
                tx_bit_q   <= '0;
            end
        end else if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    // Line is synchronised inverted so a zero register reads as an idle-high line.
    always_ff @(posedge clk_50m) begin
        rx_meta_n_q <= ~Rx;
        rx_sync_n_q <= rx_meta_n_q;
        if (ready_clr || clear) ready_q <= 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_sync_n_q) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= R_START;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_state_q <= rx_sync_n_q ? R_BITS : R_IDLE;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 16'd1;
                end
            end
            R_BITS: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {~rx_sync_n_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                    else                  rx_bit_q   <= rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= R_IDLE;
                    // A byte with a bad stop bit is dropped.
                    if (!rx_sync_n_q) begin
                        data_out_q <= rx_shift_q;
                        ready_q    <= 1'b1;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q + 16'd1;
                end
            end
        endcase
    end
endmodule

module bus_bridge_target_uart_link
    import bus_bridge_pkg::*;
#(
    parameter logic [31:0] RESP_TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          CLKS_PER_BIT        = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  bus_bridge_req_t  req_payload,
    output logic             resp_valid,
    input  logic             resp_ready,
    output bus_bridge_resp_t resp_payload,
    output logic             uart_tx,
    input  logic             uart_rx,
    output logic             flag_err,
    output logic             timeout_pulse
);
    typedef enum logic [2:0] {IDLE, TX_SEND, TX_WAIT, RX_DATA, RX_FLAGS, RESP_HOLD} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    bus_bridge_req_t  req_q, req_d;
    bus_bridge_resp_t resp_q, resp_d;
    logic             resp_valid_q, resp_valid_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       data_in_q, data_in_d;
    logic             ready_clr_q, ready_clr_d;
    logic             flag_err_q, flag_err_d;
    logic             tx_busy_q;

    logic       uart_busy, uart_ready;
    logic [7:0] rx_data;
    logic       tx_done, rx_ready;
    logic [7:0] tx_byte;

    uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk_50m   (clk),
        .data_in   (data_in_q),
        .wr_en     (wr_en_q),
        .clear     (1'b0),
        .Tx        (uart_tx),
        .Tx_busy   (uart_busy),
        .Rx        (uart_rx),
        .ready     (uart_ready),
        .ready_clr (ready_clr_q),
        .data_out  (rx_data)
    );

    assign tx_done = tx_busy_q & ~uart_busy;
    // ready is still high the cycle after we clear it; don't consume the same byte twice.
    assign rx_ready = uart_ready & ~ready_clr_q;

    always_comb begin
        case (idx_q)
            2'd0:    tx_byte = req_q.addr[7:0];
            2'd1:    tx_byte = req_q.addr[15:8];
            2'd2:    tx_byte = req_q.write_data;
            default: tx_byte = {7'b0, req_q.is_write};
        endcase
    end

`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        timeout_q, timeout_d;
    logic        to_expired;

    assign to_expired    = (to_cnt_q == RESP_TIMEOUT_CYCLES - 32'd1);
    assign timeout_pulse = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if ((state_q == RX_DATA || state_q == RX_FLAGS) && !rx_ready && !to_expired)
                to_cnt_q <= to_cnt_q + 32'd1;
            else
                to_cnt_q <= '0;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        req_d        = req_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        wr_en_d      = 1'b0;
        data_in_d    = data_in_q;
        ready_clr_d  = 1'b0;
        flag_err_d   = 1'b0;
`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE, TX_SEND, TX_WAIT: begin
                if (rx_ready) begin
                    ready_clr_d = 1'b1;
                    flag_err_d  = 1'b1;
                end
                if (state_q == IDLE && req_valid) begin
                    req_d   = req_payload;
                    idx_d   = 2'd0;
                    state_d = TX_SEND;
                end else if (state_q == TX_SEND && !uart_busy) begin
                    wr_en_d   = 1'b1;
                    data_in_d = tx_byte;
                    state_d   = TX_WAIT;
                end else if (state_q == TX_WAIT && tx_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = RX_DATA;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = TX_SEND;
                    end
                end
            end
            RX_DATA: begin
                if (rx_ready) begin
                    resp_d.read_data = rx_data;
                    ready_clr_d      = 1'b1;
                    state_d          = RX_FLAGS;
                end
`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
                else if (to_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            RX_FLAGS: begin
                if (rx_ready) begin
                    resp_d.is_write = rx_data[0];
                    ready_clr_d     = 1'b1;
                    resp_valid_d    = 1'b1;
                    flag_err_d      = (rx_data[0] != req_q.is_write);
                    state_d         = RESP_HOLD;
                end
`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
                else if (to_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            default: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            req_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            data_in_q    <= 8'h00;
            ready_clr_q  <= 1'b0;
            flag_err_q   <= 1'b0;
            tx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            wr_en_q      <= wr_en_d;
            data_in_q    <= data_in_d;
            ready_clr_q  <= ready_clr_d;
            flag_err_q   <= flag_err_d;
            tx_busy_q    <= uart_busy;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_payload = resp_q;
    assign flag_err     = flag_err_q;
endmodule

// File: tb/tb_bus_bridge_target_uart_link.sv
// Scoreboard bench for bus_bridge_target_uart_link: directed requests, a bit-banged peer UART,
// and decoupled monitors for the serial frame and the bridge response.
module tb_bus_bridge_target_uart_link;
    import bus_bridge_pkg::*;

    localparam int          CPB = 16;
    localparam logic [31:0] TO  = 32'd3000;

    logic clk = 1'b0;
    logic rst_n, req_valid, req_ready, resp_valid, resp_ready;
    logic uart_tx, uart_rx, flag_err, timeout_pulse;
    bus_bridge_req_t  req_payload;
    bus_bridge_resp_t resp_payload;

    int checks = 0;
    int errors = 0;
    int flag_cnt = 0;
    int to_cnt = 0;
    int f0, t0, el;
    logic [7:0]       exp_tx_q[$];
    bus_bridge_resp_t exp_resp_q[$];

    bus_bridge_target_uart_link #(.RESP_TIMEOUT_CYCLES(TO), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_payload(resp_payload),
        .uart_tx(uart_tx), .uart_rx(uart_rx),
        .flag_err(flag_err), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Response scoreboard: compare on every handshake.
    always @(negedge clk) begin
        if (flag_err) flag_cnt++;
        if (timeout_pulse) to_cnt++;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %h expected none", resp_payload);
            end else begin
                chk("resp_payload", 32'(resp_payload), 32'(exp_resp_q.pop_front()));
            end
        end
    end

    // Serial frame monitor: decode uart_tx mid-bit and compare against expected bytes.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            #1;
            chk("tx_start_bit", 32'(uart_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            chk("tx_stop_bit", 32'(uart_tx), 32'd1);
            if (exp_tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h expected none", b);
            end else begin
                chk("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
            end
        end
    end

    task automatic peer_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(CPB);
        end
        uart_rx = 1'b1;
        cyc(2 * CPB);
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] wd, input logic w);
        logic ok;
        exp_tx_q.push_back(a[7:0]);
        exp_tx_q.push_back(a[15:8]);
        exp_tx_q.push_back(wd);
        exp_tx_q.push_back({7'b0, w});
        req_payload = '{addr: a, write_data: wd, is_write: w};
        req_valid   = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready;
            cyc(1);
        end
        req_valid   = 1'b0;
        req_payload = '0;
        if (!ok) timeout_fail("req_accept");
        @(negedge clk);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
    endtask

    task automatic wait_tx(input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (exp_tx_q.size() == 0);
        end
        if (!ok) timeout_fail("tx_frame");
        cyc(2 * CPB);
    endtask

    task automatic wait_resp(input int budget);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (exp_resp_q.size() == 0);
        end
        if (!ok) timeout_fail("resp_handshake");
        cyc(2);
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0; req_valid = 1'b0; req_payload = '0; resp_ready = 1'b1; uart_rx = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_payload", 32'(resp_payload), 32'd0);
        chk("rst_flag_err", 32'(flag_err), 32'd0);
        chk("rst_timeout", 32'(timeout_pulse), 32'd0);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        cyc(1);
        rst_n = 1'b1;
        cyc(4);

        // Write, matching flags
        exp_resp_q.push_back('{read_data: 8'h00, is_write: 1'b1});
        issue(16'hA55A, 8'h3C, 1'b1);
        wait_tx(2000);
        peer_byte(8'h00);
        peer_byte(8'h01);
        wait_resp(500);
        chk("flag_write", 32'(flag_cnt), 32'd0);

        // Read with response backpressure
        resp_ready = 1'b0;
        exp_resp_q.push_back('{read_data: 8'h7E, is_write: 1'b0});
        issue(16'h0010, 8'h00, 1'b0);
        wait_tx(2000);
        peer_byte(8'h7E);
        peer_byte(8'h00);
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            ok = resp_valid;
        end
        if (!ok) timeout_fail("resp_valid_rise");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_resp_valid", 32'(resp_valid), 32'd1);
            chk("hold_resp_payload", 32'(resp_payload), 32'h0FC);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        cyc(1);
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        chk("post_hs_resp_valid", 32'(resp_valid), 32'd0);
        wait_resp(10);

        // Flag mismatch: response still delivered with received flag
        f0 = flag_cnt;
        exp_resp_q.push_back('{read_data: 8'h11, is_write: 1'b1});
        issue(16'h1234, 8'h00, 1'b0);
        wait_tx(2000);
        peer_byte(8'h11);
        peer_byte(8'h01);
        wait_resp(500);
        chk("flag_mismatch", 32'(flag_cnt - f0), 32'd1);

        // Stray byte in IDLE, then a normal write
        f0 = flag_cnt;
        peer_byte(8'h55);
        cyc(4 * CPB);
        chk("flag_stray", 32'(flag_cnt - f0), 32'd1);
        chk("stray_no_resp", 32'(resp_valid), 32'd0);
        exp_resp_q.push_back('{read_data: 8'h42, is_write: 1'b1});
        issue(16'hBEEF, 8'h81, 1'b1);
        wait_tx(2000);
        peer_byte(8'h42);
        peer_byte(8'h01);
        wait_resp(500);
        chk("flag_after_stray", 32'(flag_cnt - f0), 32'd1);

`ifdef BUS_BRIDGE_UART_TIMEOUT_EN
        // Only the data byte comes back
        t0 = to_cnt;
        issue(16'h0102, 8'h00, 1'b0);
        wait_tx(2000);
        peer_byte(8'h22);
        el = 0;
        ok = 1'b0;
        for (int n = 0; n < int'(TO) + 1000 && !ok; n++) begin
            @(negedge clk);
            el++;
            ok = (to_cnt != t0);
        end
        if (!ok) timeout_fail("timeout_pulse_wait");
        chk("timeout_window", 32'(el >= 2900 && el <= 3100), 32'd1);
        cyc(3);
        @(negedge clk);
        chk("timeout_count", 32'(to_cnt - t0), 32'd1);
        chk("timeout_req_ready", 32'(req_ready), 32'd1);
        chk("timeout_resp_valid", 32'(resp_valid), 32'd0);
`endif

        // Reset while byte2 is on the wire; that byte still completes
        issue(16'h6789, 8'hAB, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = (exp_tx_q.size() == 2);
        end
        if (!ok) timeout_fail("mid_frame_wait");
        cyc(3 * CPB);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp_payload", 32'(resp_payload), 32'd0);
        chk("mid_rst_flag_err", 32'(flag_err), 32'd0);
        void'(exp_tx_q.pop_back());
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        exp_resp_q.push_back('{read_data: 8'h99, is_write: 1'b0});
        issue(16'h0F0E, 8'h5A, 1'b0);
        wait_tx(3000);
        peer_byte(8'h99);
        peer_byte(8'h00);
        wait_resp(500);

        cyc(10);
        chk("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
        chk("resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
        chk("flag_total", 32'(flag_cnt), 32'd2);
`ifndef BUS_BRIDGE_UART_TIMEOUT_EN
        chk("timeout_never", 32'(to_cnt), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
